// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame states, prefix
// codes and the {ext, brk, code} FIFO entry layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         ENTRY_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is only taken when a
// pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign full_o  = (count_r == DEPTH_C);
  assign empty_o = (count_r == '0);
  assign count_o = count_r;
  assign data_o  = mem_r[rptr_r];

  // Accepted push/pop qualification.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) wptr_r <= wptr_r + 1'b1;
      if (do_pop_s)  rptr_r <= rptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wptr_r] <= data_i;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin sync, clock filter, frame FSM with timeout,
// E0/F0 prefix folding and a buffered valid/ready output.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ps2_clk_i,
  input  logic                        ps2_data_i,
  output logic [7:0]                  code_o,
  output logic                        ext_o,
  output logic                        brk_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        err_o,
  output logic                        ovf_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int            FW        = $clog2(FILTER_LEN);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic          filt_r, fall_r;
  logic [FW-1:0] filt_cnt_r;
  frame_state_e  state_r, state_nx_s;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          par_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_hit_s, byte_ok_s, frame_err_s;
  logic          ext_pend_r, brk_pend_r, push_r, err_r;
  ps2_entry_t    push_data_r, head_s;
  logic          full_s, empty_s, pop_s;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk_i;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_data_i;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Clock filter: accept a new level after FILTER_LEN consecutive samples of it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= '0;
      fall_r     <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      if (clk_sync_r != filt_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_r     <= clk_sync_r;
          filt_cnt_r <= '0;
          fall_r     <= ~clk_sync_r;
        end else begin
          filt_cnt_r <= filt_cnt_r + 1'b1;
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  assign tmo_hit_s = (state_r != IDLE) && !fall_r && (tmo_cnt_r == TMO_LAST);

  // Frame state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Frame next-state logic; a timeout overrides everything.
  always_comb begin
    state_nx_s = state_r;
    if (tmo_hit_s) begin
      state_nx_s = IDLE;
    end else if (fall_r) begin
      case (state_r)
        IDLE:    state_nx_s = dat_sync_r ? IDLE : DATA;
        DATA:    state_nx_s = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_nx_s = STOP;
        STOP:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Frame outcome strobes, valid on the stop-bit fall.
  always_comb begin
    byte_ok_s   = 1'b0;
    frame_err_s = 1'b0;
    if (fall_r && (state_r == STOP)) begin
      if (dat_sync_r && odd_parity_ok(shift_r, par_r)) byte_ok_s = 1'b1;
      else                                             frame_err_s = 1'b1;
    end else begin
      byte_ok_s   = 1'b0;
      frame_err_s = 1'b0;
    end
  end

  // Shift register, bit count, parity latch and stall timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
      par_r     <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      if (fall_r) begin
        case (state_r)
          IDLE: begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
          end
          DATA: begin
            shift_r   <= {dat_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          PARITY:  par_r <= dat_sync_r;
          default: par_r <= par_r;
        endcase
      end
      if (fall_r || (state_r == IDLE) || tmo_hit_s) tmo_cnt_r <= '0;
      else                                          tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end
  end

  // Prefix decoder: E0/F0 become flags carried into the next plain code.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      push_r      <= 1'b0;
      push_data_r <= '0;
      err_r       <= 1'b0;
    end else begin
      push_r <= 1'b0;
      err_r  <= 1'b0;
      if (frame_err_s || tmo_hit_s) begin
        err_r      <= 1'b1;
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
      end else if (byte_ok_s) begin
        case (shift_r)
          PS2_EXT: ext_pend_r <= 1'b1;
          PS2_BRK: brk_pend_r <= 1'b1;
          default: begin
            push_r      <= 1'b1;
            push_data_r <= '{ext: ext_pend_r, brk: brk_pend_r, code: shift_r};
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pop_s = valid_o && ready_i;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_r),
    .data_i  (push_data_r),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_o)
  );

  assign valid_o = !empty_s;
  assign code_o  = head_s.code;
  assign ext_o   = head_s.ext;
  assign brk_o   = head_s.brk;
  assign err_o   = err_r;
  assign ovf_o   = push_r && full_s && !pop_s;

endmodule
